csr_timer_bank: RTL and testbench
=================================

CSR_TIMER_BANK -- requirements
Module: csr_timer_bank

Interface
REQ-001 SHALL have parameter NUM_TIMERS, default 4, meaning the number of independent timer channels (legal range 1..8).
REQ-002 SHALL have parameter CNT_WIDTH, default 32, meaning the counter width in bits (legal range 8..32).
REQ-003 SHALL have parameter CSR_BASE, default 14'h0100, meaning the CSR number of timer 0 TCFG.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- csr_we  in  1  CSR write strobe.
- csr_wnum  in  14  CSR write number.
- csr_wvalue  in  32  write data.
- csr_wmask  in  32  per-bit write enable.
- csr_rnum  in  14  CSR read number.
- csr_rvalue  out  32  read data, combinational.
- timer_int  out  NUM_TIMERS  per-channel pending AND mask.
- has_timer_int  out  1  OR of timer_int.
REQ-005 SHALL use one clock and an asynchronous, active-high reset as stated in REQ-004.

Function
REQ-006 SHALL decode, per channel i at N=CSR_BASE+4*i: N+0 TCFG (bit0 EN, bit1 PERIODIC, bits[15:8] PRESCALE, other bits read 0); N+1 TINIT (bits[CNT_WIDTH-1:0]); N+2 TVAL (read-only); N+3 TICLR (write-only, reads 0).
REQ-007 SHALL decode CSR_BASE+32 as ISTAT (read-only, pending bits [NUM_TIMERS-1:0]) and CSR_BASE+33 as IMASK (bits [NUM_TIMERS-1:0]).
REQ-008 SHALL apply every register write as new = (wmask & wvalue) | (~wmask & old); writes to read-only or unmapped numbers have no effect.
REQ-009 SHALL return the zero-extended register on csr_rvalue for mapped numbers and 0 for unmapped numbers, in the same cycle.
REQ-010 SHALL define per-channel counter states: STOPPED (count all-ones), RUNNING (EN=1, count not all-ones), HALTED (EN=0, count held).
REQ-011 SHALL, on a TCFG write whose masked next value has EN=1, load count <= TINIT and clear the prescale counter on the next edge; this load overrides any tick in that cycle.
REQ-012 SHALL use TINIT as it is before any same-cycle TINIT write.
REQ-013 SHALL keep an 8-bit prescale counter per channel; while RUNNING it increments each cycle, and a tick occurs in the cycle it equals PRESCALE, after which it returns to 0; PRESCALE=0 gives a tick every cycle.
REQ-014 SHALL, on a tick with count!=0, decrement count by 1.
REQ-015 SHALL, on a tick with count==0, set pending[i]; if PERIODIC=1, reload count <= TINIT; otherwise count wraps to all-ones (STOPPED).
REQ-016 SHALL freeze count and the prescale counter when EN=0 or the channel is STOPPED.
REQ-017 SHALL clear pending[i] on a write to TICLR with wmask[0]&wvalue[0]=1; a same-cycle set (REQ-015) wins over the clear.
REQ-018 SHALL drive timer_int = pending & IMASK and has_timer_int = |timer_int combinationally from registers, so the interrupt is visible one cycle after the zero tick.
REQ-019 SHALL treat all channels fully independently; simultaneous writes target one CSR number per cycle only.
REQ-020 SHALL compute count arithmetic modulo 2^CNT_WIDTH with no carry beyond CNT_WIDTH.

Reset
REQ-021 SHALL, while reset=1, set all TCFG and TINIT to 0, all counts to all-ones, all prescale counters, pending and IMASK to 0; csr_rvalue reflects these values, and timer_int and has_timer_int are 0.
REQ-022 SHALL, on reset asserted mid-count, abandon the count immediately without generating an interrupt.

Verification
REQ-023 Scenario, one-shot: TINIT0=3, IMASK=1, TCFG0=0x1 -> TVAL0 reads 3,2,1,0 on successive cycles, then pending0=1 and has_timer_int=1, TVAL0=0xFFFFFFFF and held.
REQ-024 Scenario, periodic with prescale: TINIT1=1, TCFG1=0x0203 -> TVAL1 decrements every 3 cycles, pending1 sets every 6 cycles, and the count reloads to 1.
REQ-025 Scenario, clear race: TICLR0 write in the same cycle as channel 0 zero tick -> pending0 remains 1; a clear one cycle later -> pending0=0.
REQ-026 Scenario, masked write: TCFG0 write with wmask=0x2, wvalue=0x3 -> only PERIODIC changes, no counter load.
REQ-027 Scenario, mask gating: pending2=1, IMASK=0 -> timer_int=0 and ISTAT bit2=1; IMASK=4 -> timer_int=4.
REQ-028 Scenario, reset mid-count: reset pulse while TVAL0=5 -> TVAL0=0xFFFFFFFF, ISTAT=0, and csr_rvalue for an unmapped number is 0.

Source files
------------

// File: rtl/csr_timer_bank.sv
`default_nettype none
// ============================================================================
// Module      : csr_timer_bank
// Description : Bank of NUM_TIMERS independent down-counting timers controlled
//               through a CSR window. Each channel has its own config
//               register (TCFG), reload value (TINIT), live count (TVAL) and
//               interrupt-clear register (TICLR). The bank has one shared
//               pending status register (ISTAT) and one interrupt mask
//               register (IMASK).
// Revision    : 1.0 - initial release
// ============================================================================
module csr_timer_bank #(
    parameter int          NUM_TIMERS = 4,
    parameter int          CNT_WIDTH  = 32,
    parameter logic [13:0] CSR_BASE   = 14'h0100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  csr_we,
    input  logic [13:0]           csr_wnum,
    input  logic [31:0]           csr_wvalue,
    input  logic [31:0]           csr_wmask,
    input  logic [13:0]           csr_rnum,
    output logic [31:0]           csr_rvalue,
    output logic [NUM_TIMERS-1:0] timer_int,
    output logic                  has_timer_int
);

    // The all-ones count is the STOPPED marker; a one-shot channel parks here.
    localparam logic [CNT_WIDTH-1:0] c_ALL_ONES  = '1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [13:0]          c_ISTAT_NUM = CSR_BASE + 14'd32;
    localparam logic [13:0]          c_IMASK_NUM = CSR_BASE + 14'd33;

    // CSR number of register 'off' (0..3) in channel 'ch'
    function automatic logic [13:0] f_num(input int ch, input int off);
        return CSR_BASE + 14'(4 * ch + off);
    endfunction

    logic [NUM_TIMERS-1:0] r_en;
    logic [NUM_TIMERS-1:0] r_periodic;
    logic [7:0]            r_prescale [NUM_TIMERS];
    logic [CNT_WIDTH-1:0]  r_tinit    [NUM_TIMERS];
    logic [CNT_WIDTH-1:0]  r_count    [NUM_TIMERS];
    logic [7:0]            r_psc      [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] r_pending;
    logic [NUM_TIMERS-1:0] r_imask;

    logic [31:0]           w_wset;
    logic [31:0]           w_wkeep;
    logic                  w_hit_imask;
    logic [NUM_TIMERS-1:0] w_hit_tcfg;
    logic [NUM_TIMERS-1:0] w_hit_tinit;
    logic [NUM_TIMERS-1:0] w_hit_ticlr;
    logic [NUM_TIMERS-1:0] w_en_new;
    logic [NUM_TIMERS-1:0] w_load;
    logic [NUM_TIMERS-1:0] w_running;
    logic [NUM_TIMERS-1:0] w_tick;
    logic [NUM_TIMERS-1:0] w_zero_tick;
    logic [NUM_TIMERS-1:0] w_pend_clr;

    // Masked-write helpers: bits to force from wvalue, and bits to keep.
    assign w_wset      = csr_wmask & csr_wvalue;
    assign w_wkeep     = ~csr_wmask;
    assign w_hit_imask = csr_we && (csr_wnum == c_IMASK_NUM);

    // Per-channel write decode and count-event qualification
    always_comb begin
        w_hit_tcfg  = '0;
        w_hit_tinit = '0;
        w_hit_ticlr = '0;
        w_en_new    = '0;
        w_load      = '0;
        w_running   = '0;
        w_tick      = '0;
        w_zero_tick = '0;
        w_pend_clr  = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            w_hit_tcfg[i]  = csr_we && (csr_wnum == f_num(i, 0));
            w_hit_tinit[i] = csr_we && (csr_wnum == f_num(i, 1));
            w_hit_ticlr[i] = csr_we && (csr_wnum == f_num(i, 3));
            w_en_new[i]    = w_wset[0] | (w_wkeep[0] & r_en[i]);
            // A TCFG write that leaves EN set restarts the channel and
            // suppresses whatever tick would otherwise occur this cycle.
            w_load[i]      = w_hit_tcfg[i] && w_en_new[i];
            w_running[i]   = r_en[i] && (r_count[i] != c_ALL_ONES);
            w_tick[i]      = w_running[i] && !w_load[i] &&
                             (r_psc[i] == r_prescale[i]);
            w_zero_tick[i] = w_tick[i] && (r_count[i] == '0);
            w_pend_clr[i]  = w_hit_ticlr[i] && w_wset[0];
        end
    end

    // Register file, counters and prescalers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en       <= '0;
            r_periodic <= '0;
            r_pending  <= '0;
            r_imask    <= '0;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                r_prescale[i] <= '0;
                r_tinit[i]    <= '0;
                r_count[i]    <= c_ALL_ONES;
                r_psc[i]      <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (w_hit_tcfg[i]) begin
                    r_en[i]       <= w_en_new[i];
                    r_periodic[i] <= w_wset[1] | (w_wkeep[1] & r_periodic[i]);
                    r_prescale[i] <= w_wset[15:8] | (w_wkeep[15:8] & r_prescale[i]);
                end
                if (w_hit_tinit[i]) begin
                    r_tinit[i] <= w_wset[CNT_WIDTH-1:0] |
                                  (w_wkeep[CNT_WIDTH-1:0] & r_tinit[i]);
                end
                // Load uses the pre-write TINIT since r_tinit updates on this edge too.
                if (w_load[i]) begin
                    r_count[i] <= r_tinit[i];
                    r_psc[i]   <= '0;
                end else if (w_tick[i]) begin
                    r_psc[i] <= '0;
                    if (r_count[i] == '0) begin
                        r_count[i] <= r_periodic[i] ? r_tinit[i] : c_ALL_ONES;
                    end else begin
                        r_count[i] <= r_count[i] - c_CNT_ONE;
                    end
                end else if (w_running[i]) begin
                    r_psc[i] <= r_psc[i] + 8'd1;
                end
            end
            // A zero tick in the same cycle as a clear keeps the bit set.
            r_pending <= w_zero_tick | (r_pending & ~w_pend_clr);
            if (w_hit_imask) begin
                r_imask <= w_wset[NUM_TIMERS-1:0] |
                           (w_wkeep[NUM_TIMERS-1:0] & r_imask);
            end
        end
    end

    // Combinational CSR read mux; unmapped numbers and TICLR read zero
    always_comb begin
        csr_rvalue = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (csr_rnum == f_num(i, 0)) begin
                csr_rvalue = {16'd0, r_prescale[i], 6'd0, r_periodic[i], r_en[i]};
            end
            if (csr_rnum == f_num(i, 1)) begin
                csr_rvalue = 32'(r_tinit[i]);
            end
            if (csr_rnum == f_num(i, 2)) begin
                csr_rvalue = 32'(r_count[i]);
            end
        end
        if (csr_rnum == c_ISTAT_NUM) begin
            csr_rvalue = 32'(r_pending);
        end
        if (csr_rnum == c_IMASK_NUM) begin
            csr_rvalue = 32'(r_imask);
        end
    end

    assign timer_int     = r_pending & r_imask;
    assign has_timer_int = |timer_int;

endmodule
`default_nettype wire

// File: tb/tb_csr_timer_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_timer_bank
// Description : Self-checking bench for csr_timer_bank. A reference model of
//               the timer bank compares every read, interrupt vector and
//               summary interrupt on each falling edge; directed scenarios
//               add hand-computed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_timer_bank;

    localparam int          NT   = 4;
    localparam logic [13:0] BASE = 14'h0100;
    localparam logic [31:0] ALL  = 32'hFFFF_FFFF;
    localparam logic [13:0] ISTAT = BASE + 14'd32;
    localparam logic [13:0] IMASK = BASE + 14'd33;

    logic          clk;
    logic          reset;
    logic          csr_we;
    logic [13:0]   csr_wnum;
    logic [31:0]   csr_wvalue;
    logic [31:0]   csr_wmask;
    logic [13:0]   csr_rnum;
    logic [31:0]   csr_rvalue;
    logic [NT-1:0] timer_int;
    logic          has_timer_int;

    int n_vec = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    csr_timer_bank #(.NUM_TIMERS(NT), .CNT_WIDTH(32), .CSR_BASE(BASE)) dut (
        .clk           (clk),
        .reset         (reset),
        .csr_we        (csr_we),
        .csr_wnum      (csr_wnum),
        .csr_wvalue    (csr_wvalue),
        .csr_wmask     (csr_wmask),
        .csr_rnum      (csr_rnum),
        .csr_rvalue    (csr_rvalue),
        .timer_int     (timer_int),
        .has_timer_int (has_timer_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0]   m_cfg   [NT];
    logic [31:0]   m_tinit [NT];
    logic [31:0]   m_count [NT];
    int            m_psc   [NT];
    logic [NT-1:0] m_pending;
    logic [NT-1:0] m_imask;

    function automatic logic [13:0] num(input int ch, input int off);
        return BASE + 14'(4 * ch + off);
    endfunction

    function automatic logic [31:0] m_read(input logic [13:0] n);
        for (int i = 0; i < NT; i++) begin
            if (n == num(i, 0)) return m_cfg[i];
            if (n == num(i, 1)) return m_tinit[i];
            if (n == num(i, 2)) return m_count[i];
            if (n == num(i, 3)) return 32'd0;
        end
        if (n == ISTAT) return 32'(m_pending);
        if (n == IMASK) return 32'(m_imask);
        return 32'd0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NT; i++) begin
            m_cfg[i] = '0; m_tinit[i] = '0; m_count[i] = ALL; m_psc[i] = 0;
        end
        m_pending = '0;
        m_imask   = '0;
    endtask

    // One clock of the bank, evaluated from the pre-edge state and inputs
    task automatic m_step();
        logic [31:0]   wset, wkeep, ncfg, old_tinit;
        logic [NT-1:0] set_p, clr_p;
        logic          hit_cfg;
        wset  = csr_wmask & csr_wvalue;
        wkeep = ~csr_wmask;
        set_p = '0;
        clr_p = '0;
        for (int i = 0; i < NT; i++) begin
            old_tinit = m_tinit[i];
            hit_cfg   = csr_we && (csr_wnum == num(i, 0));
            ncfg      = (wset | (wkeep & m_cfg[i])) & 32'h0000_FF03;
            if (hit_cfg && ncfg[0]) begin
                m_count[i] = old_tinit;
                m_psc[i]   = 0;
            end else if (m_cfg[i][0] && m_count[i] != ALL) begin
                if (m_psc[i] == int'(m_cfg[i][15:8])) begin
                    m_psc[i] = 0;
                    if (m_count[i] == 0) begin
                        set_p[i]   = 1'b1;
                        m_count[i] = m_cfg[i][1] ? old_tinit : ALL;
                    end else begin
                        m_count[i] = m_count[i] - 1;
                    end
                end else begin
                    m_psc[i] = m_psc[i] + 1;
                end
            end
            if (hit_cfg) m_cfg[i] = ncfg;
            if (csr_we && csr_wnum == num(i, 1)) m_tinit[i] = wset | (wkeep & old_tinit);
            if (csr_we && csr_wnum == num(i, 3) && wset[0]) clr_p[i] = 1'b1;
        end
        m_pending = set_p | (m_pending & ~clr_p);
        if (csr_we && csr_wnum == IMASK) m_imask = wset[NT-1:0] | (wkeep[NT-1:0] & m_imask);
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) m_reset();
        else       m_step();
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_rvalue", csr_rvalue, m_read(csr_rnum));
            check("model_timer_int", 32'(timer_int), 32'(m_pending & m_imask));
            check("model_has_int", 32'(has_timer_int), 32'(|(m_pending & m_imask)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one write, captured on the next rising edge; returns 1 unit after it
    task automatic wr(input logic [13:0] n, input logic [31:0] v, input logic [31:0] m);
        csr_we = 1'b1; csr_wnum = n; csr_wvalue = v; csr_wmask = m;
        @(posedge clk);
        #1;
        csr_we = 1'b0; csr_wnum = '0; csr_wvalue = '0; csr_wmask = '0;
    endtask

    task automatic rd(input string name, input logic [13:0] n, input logic [31:0] exp);
        csr_rnum = n;
        #1;
        check(name, csr_rvalue, exp);
    endtask

    initial begin
        reset = 1'b1; csr_we = 1'b0; csr_wnum = '0; csr_wvalue = '0;
        csr_wmask = '0; csr_rnum = num(0, 2);
        cyc(2);
        chk_en = 1'b1;
        // Reset state
        rd("rst_tval0", num(0, 2), ALL);
        rd("rst_tcfg0", num(0, 0), 32'd0);
        rd("rst_istat", ISTAT, 32'd0);
        check("rst_timer_int", 32'(timer_int), 32'd0);
        check("rst_has_int", 32'(has_timer_int), 32'd0);
        reset = 1'b0;
        cyc(1);

        // One-shot countdown 3,2,1,0 then STOPPED with interrupt
        wr(num(0, 1), 32'd3, ALL);
        wr(IMASK, 32'd1, ALL);
        csr_rnum = num(0, 2);
        wr(num(0, 0), 32'h1, ALL);
        rd("oneshot_tval_3", num(0, 2), 32'd3);
        cyc(1); rd("oneshot_tval_2", num(0, 2), 32'd2);
        cyc(1); rd("oneshot_tval_1", num(0, 2), 32'd1);
        cyc(1); rd("oneshot_tval_0", num(0, 2), 32'd0);
        check("oneshot_no_int_yet", 32'(has_timer_int), 32'd0);
        cyc(1); rd("oneshot_tval_stop", num(0, 2), ALL);
        check("oneshot_has_int", 32'(has_timer_int), 32'd1);
        rd("oneshot_istat", ISTAT, 32'd1);
        cyc(3); rd("oneshot_tval_held", num(0, 2), ALL);

        // Clear racing with the zero tick: set wins, later clear works
        wr(num(0, 3), 32'd1, 32'd1);
        rd("clr_istat_0", ISTAT, 32'd0);
        wr(num(0, 0), 32'h1, ALL);
        cyc(3);
        wr(num(0, 3), 32'd1, 32'd1);
        rd("race_istat_kept", ISTAT, 32'd1);
        wr(num(0, 3), 32'd1, 32'd1);
        rd("race_istat_cleared", ISTAT, 32'd0);

        // Masked TCFG write touches only PERIODIC, no load
        wr(num(0, 0), 32'h0, ALL);
        wr(num(0, 0), 32'h3, 32'h2);
        rd("mask_tcfg0", num(0, 0), 32'h2);
        rd("mask_tval0", num(0, 2), ALL);

        // IMASK gating of a pending channel 2
        wr(IMASK, 32'd0, ALL);
        wr(num(2, 1), 32'd0, ALL);
        wr(num(2, 0), 32'h1, ALL);
        cyc(1);
        rd("gate_istat", ISTAT, 32'd4);
        check("gate_timer_int_off", 32'(timer_int), 32'd0);
        check("gate_has_int_off", 32'(has_timer_int), 32'd0);
        wr(IMASK, 32'd4, ALL);
        check("gate_timer_int_on", 32'(timer_int), 32'd4);
        check("gate_has_int_on", 32'(has_timer_int), 32'd1);

        // Periodic channel 1 with PRESCALE=2
        wr(IMASK, 32'd6, ALL);
        wr(num(1, 1), 32'd1, ALL);
        csr_rnum = num(1, 2);
        wr(num(1, 0), 32'h0203, ALL);
        rd("per_tval_1", num(1, 2), 32'd1);
        check("per_int_before", 32'(timer_int), 32'd4);
        cyc(2); rd("per_tval_still_1", num(1, 2), 32'd1);
        cyc(1); rd("per_tval_0", num(1, 2), 32'd0);
        cyc(3); rd("per_tval_reload", num(1, 2), 32'd1);
        check("per_int_after", 32'(timer_int), 32'd6);
        cyc(12);

        // Reset in the middle of a count
        rd("unmapped_live", BASE + 14'd20, 32'd0);
        rd("ticlr_reads_0", num(0, 3), 32'd0);
        wr(num(0, 1), 32'd9, ALL);
        csr_rnum = num(0, 2);
        wr(num(0, 0), 32'h1, ALL);
        cyc(4);
        rd("rstmid_tval_5", num(0, 2), 32'd5);
        reset = 1'b1;
        rd("rstmid_tval", num(0, 2), ALL);
        rd("rstmid_istat", ISTAT, 32'd0);
        rd("rstmid_unmapped", 14'h3FFF, 32'd0);
        check("rstmid_timer_int", 32'(timer_int), 32'd0);
        cyc(1);
        reset = 1'b0;
        cyc(5);
        rd("post_rst_tval", num(0, 2), ALL);
        rd("post_rst_istat", ISTAT, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
